// File: rtl/ram_seq_pkg.sv
// Shared types and helpers for the asynchronous RAM sequencer.
package ram_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold
  } state_e;

  // The counter must hold the largest phase length minus one; the +1 keeps width >= 1.
  function automatic int unsigned cnt_width(input int unsigned setup_c,
                                            input int unsigned access_c,
                                            input int unsigned hold_c);
    int unsigned m;
    m = setup_c;
    if (access_c > m) m = access_c;
    if (hold_c > m) m = hold_c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/ram_seq_timer.sv
// Loadable down-counter with a zero flag, shared by the timed sequencer phases.
module ram_seq_timer #(
  parameter int unsigned Width = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic             zero
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/ram_sequencer.sv
// Converts a valid/ready request stream into registered CS/WE/OE strobes for an async RAM.
module ram_sequencer
  import ram_seq_pkg::*;
#(
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned ACCESS_CYCLES = 5,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_cs_bar,
  output logic              ram_we_bar,
  output logic              ram_oe_bar
);

  localparam int unsigned CntW = cnt_width(SETUP_CYCLES, ACCESS_CYCLES, HOLD_CYCLES);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              write_q, write_d;
  logic              cs_bar_q, cs_bar_d;
  logic              we_bar_q, we_bar_d;
  logic              oe_bar_q, oe_bar_d;
  logic              rsp_valid_q, rsp_valid_d;

  logic              tmr_load;
  logic [CntW-1:0]   tmr_val;
  logic              tmr_zero;

  ram_seq_timer #(
    .Width(CntW)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .load_val(tmr_val),
    .zero    (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    write_d     = write_q;
    cs_bar_d    = 1'b1;
    we_bar_d    = 1'b1;
    oe_bar_d    = 1'b1;
    rsp_valid_d = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          write_d  = req_write;
          state_d  = StSetup;
          tmr_load = 1'b1;
          tmr_val  = CntW'(SETUP_CYCLES - 1);
        end
      end
      StSetup: begin
        if (tmr_zero) begin
          state_d  = StStrobe;
          tmr_load = 1'b1;
          tmr_val  = CntW'(ACCESS_CYCLES - 1);
          cs_bar_d = 1'b0;
          we_bar_d = ~write_q;
          oe_bar_d = write_q;
        end
      end
      StStrobe: begin
        if (tmr_zero) begin
          // Read data is sampled on the same edge that releases the strobes.
          state_d  = StHold;
          tmr_load = 1'b1;
          tmr_val  = CntW'(HOLD_CYCLES - 1);
          if (!write_q) begin
            rdata_d = ram_rdata;
          end
        end else begin
          cs_bar_d = cs_bar_q;
          we_bar_d = we_bar_q;
          oe_bar_d = oe_bar_q;
        end
      end
      StHold: begin
        if (tmr_zero) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      write_q     <= 1'b0;
      cs_bar_q    <= 1'b1;
      we_bar_q    <= 1'b1;
      oe_bar_q    <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      write_q     <= write_d;
      cs_bar_q    <= cs_bar_d;
      we_bar_q    <= we_bar_d;
      oe_bar_q    <= oe_bar_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rdata_q;
  assign ram_addr   = addr_q;
  assign ram_wdata  = wdata_q;
  assign ram_cs_bar = cs_bar_q;
  assign ram_we_bar = we_bar_q;
  assign ram_oe_bar = oe_bar_q;

endmodule

// File: tb/tb_ram_sequencer.sv
// Directed and random checks of ram_sequencer against async RAM models and a scoreboard.
module tb_ram_sequencer;

  localparam int S1 = 1, A1 = 5, H1 = 1;
  localparam int S2 = 2, A2 = 3, H2 = 2;

  logic clk, reset;
  int   total = 0, bad = 0;

  // Instance 1: default timing
  logic        req_valid1, req_ready1, req_write1, rsp_valid1;
  logic [15:0] req_addr1, ram_addr1;
  logic [7:0]  req_wdata1, rsp_rdata1, ram_wdata1;
  wire  [7:0]  ram_rdata1;
  logic        ram_cs_bar1, ram_we_bar1, ram_oe_bar1;
  logic [7:0]  mem1 [65536];

  // Instance 2: SETUP=2 / ACCESS=3 / HOLD=2
  logic        req_valid2, req_ready2, req_write2, rsp_valid2;
  logic [15:0] req_addr2, ram_addr2;
  logic [7:0]  req_wdata2, rsp_rdata2, ram_wdata2;
  wire  [7:0]  ram_rdata2;
  logic        ram_cs_bar2, ram_we_bar2, ram_oe_bar2;
  logic [7:0]  mem2 [65536];
  logic [7:0]  sb2 [16];

  ram_sequencer u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
    .req_addr(req_addr1), .req_wdata(req_wdata1),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1),
    .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1),
    .ram_cs_bar(ram_cs_bar1), .ram_we_bar(ram_we_bar1), .ram_oe_bar(ram_oe_bar1)
  );

  ram_sequencer #(
    .SETUP_CYCLES(S2), .ACCESS_CYCLES(A2), .HOLD_CYCLES(H2)
  ) u_dut2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_write(req_write2),
    .req_addr(req_addr2), .req_wdata(req_wdata2),
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2),
    .ram_addr(ram_addr2), .ram_wdata(ram_wdata2), .ram_rdata(ram_rdata2),
    .ram_cs_bar(ram_cs_bar2), .ram_we_bar(ram_we_bar2), .ram_oe_bar(ram_oe_bar2)
  );

  // Async RAM models: output driven only while selected with OE low
  assign ram_rdata1 = (!ram_cs_bar1 && !ram_oe_bar1) ? mem1[ram_addr1] : 8'hzz;
  assign ram_rdata2 = (!ram_cs_bar2 && !ram_oe_bar2) ? mem2[ram_addr2] : 8'hzz;

  always @(posedge clk) begin
    if (!ram_cs_bar1 && !ram_we_bar1) mem1[ram_addr1] <= ram_wdata1;
    if (!ram_cs_bar2 && !ram_we_bar2) mem2[ram_addr2] <= ram_wdata2;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe invariants on both instances, every cycle
  always @(negedge clk) begin
    if (!reset) begin
      check("inv1_we_oe", {31'd0, ram_we_bar1 | ram_oe_bar1}, 32'd1);
      check("inv1_cs", {31'd0, (ram_we_bar1 & ram_oe_bar1) | ~ram_cs_bar1}, 32'd1);
      check("inv2_we_oe", {31'd0, ram_we_bar2 | ram_oe_bar2}, 32'd1);
      check("inv2_cs", {31'd0, (ram_we_bar2 & ram_oe_bar2) | ~ram_cs_bar2}, 32'd1);
    end
  end

  initial begin
    #1_000_000;
    bad++;
    $display("FAIL watchdog expired total=%0d", total);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // One access on instance 1, entered and left at a negedge; noise drives random requests while busy.
  task automatic op1(input bit wr, input logic [15:0] a, input logic [7:0] d,
                     input logic [7:0] exp_rd, input bit noise);
    int first_low, n_low, rsp_at;
    logic [7:0] prev_rd;
    prev_rd = rsp_rdata1;
    check("ready_before", {31'd0, req_ready1}, 32'd1);
    req_valid1 = 1'b1; req_write1 = wr; req_addr1 = a; req_wdata1 = d;
    @(posedge clk);
    #1 req_valid1 = 1'b0;
    first_low = -1; n_low = 0; rsp_at = -1;
    for (int k = 0; k < 30 && rsp_at < 0; k++) begin
      @(negedge clk);
      if (!ram_cs_bar1) begin
        if (first_low < 0) first_low = k;
        n_low++;
        check("we_dir", {31'd0, ram_we_bar1}, {31'd0, ~wr});
        check("oe_dir", {31'd0, ram_oe_bar1}, {31'd0, wr});
      end else begin
        check("we_idle", {31'd0, ram_we_bar1}, 32'd1);
        check("oe_idle", {31'd0, ram_oe_bar1}, 32'd1);
      end
      check("addr_stable", {16'd0, ram_addr1}, {16'd0, a});
      check("wdata_stable", {24'd0, ram_wdata1}, {24'd0, d});
      if (rsp_valid1) begin
        rsp_at = k;
      end else begin
        check("ready_busy", {31'd0, req_ready1}, 32'd0);
        if (noise) begin
          req_valid1 = 1'($urandom); req_write1 = 1'($urandom);
          req_addr1 = 16'($urandom); req_wdata1 = 8'($urandom);
        end
      end
    end
    req_valid1 = 1'b0;
    check("strobe_start", first_low, S1);
    check("strobe_len", n_low, A1);
    check("rsp_latency", rsp_at, S1 + A1 + H1);
    check("rsp_rdata", {24'd0, rsp_rdata1}, {24'd0, wr ? prev_rd : exp_rd});
  endtask

  initial begin
    bit          wr;
    logic [15:0] a;
    logic [7:0]  d;
    int          n_low, rsp_at, rsp_cnt;

    for (int i = 0; i < 65536; i++) begin
      mem1[i] = 8'h00;
      mem2[i] = 8'h00;
    end
    for (int i = 0; i < 16; i++) sb2[i] = 8'h00;
    reset = 1'b1;
    req_valid1 = 0; req_write1 = 0; req_addr1 = 0; req_wdata1 = 0;
    req_valid2 = 0; req_write2 = 0; req_addr2 = 0; req_wdata2 = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cs", {31'd0, ram_cs_bar1}, 32'd1);
    check("rst_we", {31'd0, ram_we_bar1}, 32'd1);
    check("rst_oe", {31'd0, ram_oe_bar1}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid1}, 32'd0);
    check("rst_rdata", {24'd0, rsp_rdata1}, 32'd0);
    check("rst_addr", {16'd0, ram_addr1}, 32'd0);
    check("rst_wdata", {24'd0, ram_wdata1}, 32'd0);
    reset = 1'b0;
    #1 check("rst_ready", {31'd0, req_ready1}, 32'd1);
    @(negedge clk);

    // Write then read back
    op1(1'b1, 16'h1234, 8'hA5, 8'h00, 1'b0);
    check("ram_model_1234", {24'd0, mem1[16'h1234]}, 32'h0000_00A5);
    @(negedge clk);
    op1(1'b0, 16'h1234, 8'h5A, 8'hA5, 1'b0);
    @(negedge clk);

    // Back-to-back: read accepted on the write's rsp_valid cycle
    op1(1'b1, 16'h0001, 8'h3C, 8'h00, 1'b0);
    check("b2b_rsp_cycle", {31'd0, rsp_valid1}, 32'd1);
    op1(1'b0, 16'h0001, 8'h77, 8'h3C, 1'b0);

    // Noise on the request port while busy
    op1(1'b0, 16'h1234, 8'hC3, 8'hA5, 1'b1);
    @(negedge clk);
    check("noise_single_rsp", {31'd0, rsp_valid1}, 32'd0);
    op1(1'b1, 16'hBEEF, 8'h81, 8'h00, 1'b1);
    @(negedge clk);
    check("noise_single_rsp_w", {31'd0, rsp_valid1}, 32'd0);
    check("ram_model_beef", {24'd0, mem1[16'hBEEF]}, 32'h0000_0081);

    // Reset in the third strobe cycle of a write
    req_valid1 = 1'b1; req_write1 = 1'b1; req_addr1 = 16'h0042; req_wdata1 = 8'h99;
    @(posedge clk);
    #1 req_valid1 = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_strobe_cs", {31'd0, ram_cs_bar1}, 32'd0);
    reset = 1'b1;
    #1;
    check("arst_cs", {31'd0, ram_cs_bar1}, 32'd1);
    check("arst_we", {31'd0, ram_we_bar1}, 32'd1);
    check("arst_oe", {31'd0, ram_oe_bar1}, 32'd1);
    check("arst_rsp_valid", {31'd0, rsp_valid1}, 32'd0);
    check("arst_rdata", {24'd0, rsp_rdata1}, 32'd0);
    check("arst_addr", {16'd0, ram_addr1}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("arst_ready", {31'd0, req_ready1}, 32'd1);
    rsp_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid1) rsp_cnt++;
    end
    check("arst_no_rsp", rsp_cnt, 0);
    check("arst_cs_idle", {31'd0, ram_cs_bar1}, 32'd1);

    // Random traffic on instance 2
    for (int i = 0; i < 1000; i++) begin
      wr = 1'($urandom);
      a  = 16'($urandom_range(0, 15));
      d  = 8'($urandom);
      check("r_ready", {31'd0, req_ready2}, 32'd1);
      req_valid2 = 1'b1; req_write2 = wr; req_addr2 = a; req_wdata2 = d;
      @(posedge clk);
      #1 req_valid2 = 1'b0;
      n_low = 0; rsp_at = -1;
      for (int k = 0; k < 40 && rsp_at < 0; k++) begin
        @(negedge clk);
        if (!ram_cs_bar2) n_low++;
        if (rsp_valid2) rsp_at = k;
      end
      check("r_strobe_len", n_low, A2);
      check("r_latency", rsp_at, S2 + A2 + H2);
      if (wr) sb2[a[3:0]] = d;
      else check("r_rdata", {24'd0, rsp_rdata2}, {24'd0, sb2[a[3:0]]});
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
